// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, FSM states and event layout for the PS/2 receiver
package ps2_pkg;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam int PS2_FRAME_BITS = 11;
    typedef enum logic [1:0] {IDLE, RECV, CHECK} ps2_state_t;
    typedef struct packed {
        logic ext;
        logic brk;
        logic [7:0] code;
    } ps2_event_t;
    localparam int EV_W = $bits(ps2_event_t);
endpackage

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: first-word-fall-through event queue with drop-on-full overflow pulse
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [EV_W-1:0] din,
    input  logic            ready,
    output logic            valid,
    output logic [EV_W-1:0] dout,
    output logic            overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [EV_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0] wp, rp;
    logic full, pop, wr;
    assign valid = wp != rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign pop = valid && ready;
    assign wr = push && (!full || pop);
    assign dout = valid ? mem[rp[AW-1:0]] : '0;
    // pointers advance on accepted push/pop; a push into a full, non-popping queue is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
            overflow <= 1'b0;
        end else begin
            wp <= wp + (AW+1)'(wr);
            rp <= rp + (AW+1)'(pop);
            overflow <= push && full && !pop;
        end
    end
    // storage needs no reset: empty slots are never presented
    always_ff @(posedge clk) begin
        if (wr) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: PS/2 keyboard deframer, make/break/E0 decoder and event queue
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int FIFO_DEPTH = 4,
    parameter int REPEAT_SUPPRESS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       keyb_clk,
    input  logic       keyb_data,
    input  logic       ev_ready,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_break,
    output logic       ev_ext,
    output logic       frame_err,
    output logic       overflow
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [1:0] kc_sync, kd_sync;
    logic [FW-1:0] flt_cnt;
    logic fclk, fclk_d, fall, dat;
    ps2_state_t state, state_n;
    logic [3:0] bitcnt, bitcnt_n;
    logic [9:0] sr, sr_n;
    logic [TW-1:0] tmo, tmo_n;
    logic err_n, byte_vld, bvld_n;
    logic [7:0] byte_q, byte_n;
    logic ext_pend, ext_n, brk_pend, brk_n, held_v, held_v_n, push, held_match;
    logic [8:0] held, held_n, key;
    ps2_event_t ev_in, ev_out;
    assign fall = fclk_d && !fclk;
    assign dat = kd_sync[1];
    // synchronise both lines and debounce the clock until it has been stable FILTER_LEN samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kc_sync <= 2'b11;
            kd_sync <= 2'b11;
            flt_cnt <= '0;
            fclk <= 1'b1;
            fclk_d <= 1'b1;
        end else begin
            kc_sync <= {kc_sync[0], keyb_clk};
            kd_sync <= {kd_sync[0], keyb_data};
            fclk_d <= fclk;
            if (kc_sync[1] == fclk) flt_cnt <= '0;
            else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                fclk <= kc_sync[1];
                flt_cnt <= '0;
            end else flt_cnt <= flt_cnt + FW'(1);
        end
    end
    // frame FSM state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            bitcnt <= '0;
            sr <= '0;
            tmo <= '0;
            frame_err <= 1'b0;
            byte_vld <= 1'b0;
            byte_q <= '0;
        end else begin
            state <= state_n;
            bitcnt <= bitcnt_n;
            sr <= sr_n;
            tmo <= tmo_n;
            frame_err <= err_n;
            byte_vld <= bvld_n;
            byte_q <= byte_n;
        end
    end
    // start-bit qualification, LSB-first shifting with edge timeout, then parity/stop check
    always_comb begin
        state_n = state;
        bitcnt_n = bitcnt;
        sr_n = sr;
        tmo_n = '0;
        err_n = 1'b0;
        bvld_n = 1'b0;
        byte_n = byte_q;
        case (state)
            IDLE: begin
                if (fall && dat) err_n = 1'b1;
                else if (fall) begin
                    state_n = RECV;
                    bitcnt_n = 4'd1;
                end
            end
            RECV: begin
                if (fall) begin
                    sr_n = {dat, sr[9:1]};
                    bitcnt_n = bitcnt + 4'd1;
                    state_n = (bitcnt == 4'(PS2_FRAME_BITS - 1)) ? CHECK : RECV;
                end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_n = IDLE;
                    err_n = 1'b1;
                end else tmo_n = tmo + TW'(1);
            end
            CHECK: begin
                state_n = IDLE;
                bvld_n = ^sr[8:0] && sr[9];
                err_n = !(^sr[8:0] && sr[9]);
                byte_n = sr[7:0];
            end
            default: state_n = IDLE;
        endcase
    end
    assign key = {ext_pend, byte_q};
    assign held_match = held_v && held == key;
    // prefix flags and the currently held key
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            held <= '0;
            held_v <= 1'b0;
        end else begin
            ext_pend <= ext_n;
            brk_pend <= brk_n;
            held <= held_n;
            held_v <= held_v_n;
        end
    end
    // prefixes only arm flags; other bytes become events, repeated makes optionally swallowed
    always_comb begin
        ext_n = ext_pend;
        brk_n = brk_pend;
        held_n = held;
        held_v_n = held_v;
        push = 1'b0;
        if (byte_vld) begin
            if (byte_q == PS2_EXT) ext_n = 1'b1;
            else if (byte_q == PS2_BREAK) brk_n = 1'b1;
            else begin
                ext_n = 1'b0;
                brk_n = 1'b0;
                if (brk_pend) begin
                    push = 1'b1;
                    held_v_n = held_v && !held_match;
                end else begin
                    push = !(REPEAT_SUPPRESS != 0 && held_match);
                    held_n = key;
                    held_v_n = 1'b1;
                end
            end
        end
    end
    assign ev_in = '{ext: ext_pend, brk: brk_pend, code: byte_q};
    ps2_event_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .din(ev_in),
        .ready(ev_ready),
        .valid(ev_valid),
        .dout(ev_out),
        .overflow(overflow)
    );
    assign ev_code = ev_out.code;
    assign ev_break = ev_out.brk;
    assign ev_ext = ev_out.ext;
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb_ps2_scan_receiver: directed PS/2 frames against two receivers (repeat suppression on/off)
module tb_ps2_scan_receiver;
    localparam int FL = 4, TMO = 5000, H = 10;
    logic clk = 1'b0, reset = 1'b1, keyb_clk = 1'b1, keyb_data = 1'b1, ev_ready = 1'b1;
    logic [1:0] ev_valid, ev_break, ev_ext, frame_err, overflow;
    logic [7:0] ev_code [2];
    int checks = 0, errors = 0, cyc = 0, stop_cyc = 0, rise_cyc = -1, fall_cyc = -1, exp_err = 0;
    int err_seen [2], ovf_seen [2], exp_ovf [2], pops [2];
    logic [9:0] q0 [$];
    logic [9:0] q1 [$];
    logic [9:0] last_ev [2], prev_ev [2];
    logic [8:0] held [2];
    bit ext_p [2], brk_p [2], hv [2], prev_v [2];
    bit prev_r = 1'b0;

    ps2_scan_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(4), .REPEAT_SUPPRESS(1)) dut_rs (
        .clk(clk), .reset(reset), .keyb_clk(keyb_clk), .keyb_data(keyb_data), .ev_ready(ev_ready),
        .ev_valid(ev_valid[0]), .ev_code(ev_code[0]), .ev_break(ev_break[0]), .ev_ext(ev_ext[0]),
        .frame_err(frame_err[0]), .overflow(overflow[0]));
    ps2_scan_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(4), .REPEAT_SUPPRESS(0)) dut_nors (
        .clk(clk), .reset(reset), .keyb_clk(keyb_clk), .keyb_data(keyb_data), .ev_ready(ev_ready),
        .ev_valid(ev_valid[1]), .ev_code(ev_code[1]), .ev_break(ev_break[1]), .ev_ext(ev_ext[1]),
        .frame_err(frame_err[1]), .overflow(overflow[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // expected queue: 4 slots, nothing leaves while the consumer is stalled
    task automatic enq(input int i, input logic [9:0] e);
        int n;
        n = (i == 0) ? q0.size() : q1.size();
        if (!ev_ready && n >= 4) exp_ovf[i]++;
        else if (i == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // key-event semantics: instance 0 swallows a make of the key already held down
    task automatic model_byte(input int i, input logic [7:0] b);
        logic [8:0] k;
        if (b == 8'hE0) ext_p[i] = 1'b1;
        else if (b == 8'hF0) brk_p[i] = 1'b1;
        else begin
            k = {ext_p[i], b};
            if (brk_p[i]) begin
                enq(i, {ext_p[i], 1'b1, b});
                if (hv[i] && held[i] == k) hv[i] = 1'b0;
            end else if (!(i == 0 && hv[i] && held[i] == k)) begin
                enq(i, {ext_p[i], 1'b0, b});
                held[i] = k;
                hv[i] = 1'b1;
            end
            ext_p[i] = 1'b0;
            brk_p[i] = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int j = 0; j < n; j++) begin
            keyb_data = f[j];
            repeat (H) @(posedge clk);
            #1 keyb_clk = 1'b0;
            if (j == 10) stop_cyc = cyc;
            repeat (H) @(posedge clk);
            #1 keyb_clk = 1'b1;
        end
        keyb_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input bit flip);
        if (flip) exp_err++;
        else begin
            model_byte(0, b);
            model_byte(1, b);
        end
        send_bits({1'b1, (~^b) ^ flip, b, 1'b0}, 11);
        repeat (30) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        keyb_clk = 1'b1;
        keyb_data = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'({ev_valid, ev_break, ev_ext, frame_err, overflow, ev_code[0], ev_code[1]}), 0);
        q0.delete();
        q1.delete();
        exp_err = 0;
        for (int i = 0; i < 2; i++) begin
            err_seen[i] = 0; ovf_seen[i] = 0; exp_ovf[i] = 0; pops[i] = 0; last_ev[i] = '0;
            ext_p[i] = 1'b0; brk_p[i] = 1'b0; hv[i] = 1'b0; held[i] = '0; prev_v[i] = 1'b0;
        end
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic group_end(input string name);
        check({name, "_queue_drained"}, q0.size() + q1.size(), 0);
        check({name, "_err_model"}, err_seen[0], exp_err);
        check({name, "_err_both"}, err_seen[1], exp_err);
        check({name, "_ovf_model0"}, ovf_seen[0], exp_ovf[0]);
        check({name, "_ovf_model1"}, ovf_seen[1], exp_ovf[1]);
    endtask

    // per-cycle compare of every handshake and every stalled cycle against the model queues
    always @(negedge clk) begin : cmp
        logic [9:0] cur, e;
        bit has;
        if (!reset) begin
            if (ev_valid[0] && !prev_v[0]) rise_cyc = cyc;
            if (!ev_valid[0] && prev_v[0]) fall_cyc = cyc;
            for (int i = 0; i < 2; i++) begin
                cur = {ev_ext[i], ev_break[i], ev_code[i]};
                if (frame_err[i]) err_seen[i]++;
                if (overflow[i]) ovf_seen[i]++;
                if (prev_v[i] && !prev_r) begin
                    checks++;
                    if (!ev_valid[i] || cur != prev_ev[i]) begin
                        errors++;
                        $display("FAIL hold%0d: got v=%0b ev=%h required v=1 ev=%h", i, ev_valid[i], cur, prev_ev[i]);
                    end
                end
                if (ev_valid[i] && ev_ready) begin
                    checks++;
                    pops[i]++;
                    last_ev[i] = cur;
                    has = (i == 0) ? q0.size() > 0 : q1.size() > 0;
                    if (!has) begin
                        errors++;
                        $display("FAIL event%0d: got %h required no event", i, cur);
                    end else begin
                        if (i == 0) e = q0.pop_front();
                        else e = q1.pop_front();
                        if (cur != e) begin
                            errors++;
                            $display("FAIL event%0d: got %h required %h", i, cur, e);
                        end
                    end
                end
                prev_v[i] = ev_valid[i];
                prev_ev[i] = cur;
            end
            prev_r = ev_ready;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // single keypad9 make, latency and pulse width
        send(8'h7D, 1'b0);
        check("lat_rise", rise_cyc - stop_cyc, 2 + FL + 3);
        check("lat_width", fall_cyc - rise_cyc, 1);
        check("k9_pops0", pops[0], 1);
        check("k9_pops1", pops[1], 1);
        check("k9_event", int'(last_ev[0]), 'h07D);
        group_end("k9");
        // typematic repeat
        do_reset();
        send(8'h7D, 1'b0);
        send(8'h7D, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h7D, 1'b0);
        check("rep_pops_suppress", pops[0], 2);
        check("rep_pops_nosuppress", pops[1], 3);
        check("rep_last", int'(last_ev[0]), 'h17D);
        group_end("rep");
        // parity error then recovery
        do_reset();
        send(8'h79, 1'b1);
        check("par_err", err_seen[0], 1);
        check("par_no_event", pops[0], 0);
        send(8'h79, 1'b0);
        check("par_recover", int'(last_ev[0]), 'h079);
        check("par_err_once", err_seen[0], 1);
        group_end("par");
        // mid-frame timeout then recovery
        do_reset();
        send_bits({1'b1, ~^8'h70, 8'h70, 1'b0}, 5);
        exp_err++;
        repeat (TMO + 10) @(posedge clk);
        #1;
        check("tmo_err", err_seen[0], 1);
        check("tmo_no_event", pops[0], 0);
        send(8'h70, 1'b0);
        check("tmo_recover", int'(last_ev[0]), 'h070);
        check("tmo_pops", pops[0], 1);
        group_end("tmo");
        // extended make and break
        do_reset();
        send(8'hE0, 1'b0);
        send(8'h5A, 1'b0);
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h5A, 1'b0);
        check("ext_pops", pops[0], 2);
        check("ext_break", int'(last_ev[0]), 'h35A);
        group_end("ext");
        // overflow on the fifth queued make, then in-order drain
        do_reset();
        ev_ready = 1'b0;
        send(8'h16, 1'b0);
        send(8'h1E, 1'b0);
        send(8'h26, 1'b0);
        send(8'h25, 1'b0);
        send(8'h2E, 1'b0);
        check("ovf_pulse0", ovf_seen[0], 1);
        check("ovf_pulse1", ovf_seen[1], 1);
        check("ovf_head", int'({ev_valid[0], ev_ext[0], ev_break[0], ev_code[0]}), 'h416);
        ev_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("drain_pops", pops[0], 4);
        check("drain_last", int'(last_ev[0]), 'h025);
        check("drain_empty", int'(ev_valid), 0);
        group_end("ovf");
        // reset with a queued event and a partial frame discards both
        ev_ready = 1'b0;
        send(8'h16, 1'b0);
        send_bits({1'b1, ~^8'h1C, 8'h1C, 1'b0}, 4);
        do_reset();
        ev_ready = 1'b1;
        send(8'h1C, 1'b0);
        check("rst_pops", pops[0], 1);
        check("rst_event", int'(last_ev[0]), 'h01C);
        group_end("rst");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
